// File: rtl/display_page_scheduler.sv
// Round-robin sharing of the two display halves (A/B) between NUM_REQ requesters.
// Each grant shows one requester's values for DWELL_CYCLES clocks before re-arbitrating.
module display_page_scheduler #(
  parameter int NUM_WIDTH    = 8,
  parameter int NUM_REQ      = 4,
  parameter int REQ_W        = 2,
  parameter int DWELL_CYCLES = 100000000,
  parameter int CNT_W        = 27
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*NUM_WIDTH-1:0] i_req_data_a,
  input  logic [NUM_REQ*NUM_WIDTH-1:0] i_req_data_b,
  input  logic                         i_hold,
  output logic [NUM_WIDTH-1:0]         o_number_a,
  output logic [NUM_WIDTH-1:0]         o_number_b,
  output logic [REQ_W-1:0]             o_owner,
  output logic                         o_owner_valid,
  output logic [NUM_REQ-1:0]           o_ack
);

  typedef enum logic {S_IDLE = 1'b0, S_SHOW = 1'b1} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [REQ_W-1:0]      r_last;
  logic [REQ_W-1:0]      r_owner;
  logic [NUM_WIDTH-1:0]  r_number_a;
  logic [NUM_WIDTH-1:0]  r_number_b;
  logic                  r_owner_valid;
  logic [NUM_REQ-1:0]    r_ack;

  logic [NUM_WIDTH-1:0]  w_data_a [NUM_REQ];
  logic [NUM_WIDTH-1:0]  w_data_b [NUM_REQ];
  logic [REQ_W-1:0]      w_winner;
  logic                  w_any;
  logic                  w_grant;
  int                    w_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_data_a[gi] = i_req_data_a[gi*NUM_WIDTH +: NUM_WIDTH];
      assign w_data_b[gi] = i_req_data_b[gi*NUM_WIDTH +: NUM_WIDTH];
    end
  endgenerate

  // Walk from farthest to nearest candidate so the last hit is the one just after r_last.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      if (i_req[w_idx[REQ_W-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_idx[REQ_W-1:0];
      end
    end
  end

  assign w_grant = w_any && ((r_state == S_IDLE) || (!i_hold && (r_cnt == '0)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_last        <= REQ_W'(NUM_REQ - 1);
      r_owner       <= '0;
      r_number_a    <= '0;
      r_number_b    <= '0;
      r_owner_valid <= 1'b0;
      r_ack         <= '0;
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_state       <= S_SHOW;
        r_owner       <= w_winner;
        r_last        <= w_winner;
        r_number_a    <= w_data_a[w_winner];
        r_number_b    <= w_data_b[w_winner];
        r_owner_valid <= 1'b1;
        r_ack         <= NUM_REQ'(1) << w_winner;
        r_cnt         <= CNT_W'(DWELL_CYCLES - 1);
      end else if (r_state == S_SHOW) begin
        if (i_req[r_owner]) begin
          r_number_a <= w_data_a[r_owner];
          r_number_b <= w_data_b[r_owner];
        end
        if (!i_hold) begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Nobody waiting: drop the grant but keep the last page on the display.
            r_state       <= S_IDLE;
            r_owner_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign o_number_a    = r_number_a;
  assign o_number_b    = r_number_b;
  assign o_owner       = r_owner;
  assign o_owner_valid = r_owner_valid;
  assign o_ack         = r_ack;

endmodule
